// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch unit.
//   fetch_state_e : controller state (RUN / FAULT)
//   fetch_entry_t : one buffered {pc, instr} pair
//   INSTR_BYTES   : PC increment per fetched instruction
package fetch_pkg;

  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [0:0] {
    FETCH_RUN   = 1'b0,
    FETCH_FAULT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Word index of pc must lie below the ROM depth.
  function automatic logic pc_in_range(input logic [31:0] pc,
                                       input logic [31:0] mem_words);
    return ({2'b00, pc[31:2]} < mem_words);
  endfunction

  function automatic logic word_aligned(input logic [1:0] addr_lsbs);
    return (addr_lsbs == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry in-order buffer of fetch entries between fetch and decode.
//   clk, rst_n   : clock, asynchronous active-low reset
//   flush_i      : discard all entries (wins over push/pop)
//   push_i       : append push_data_i (ignored when full without a pop)
//   push_data_i  : entry to append
//   pop_i        : remove head (ignored when empty)
//   head_o       : current head entry (holds last value when empty)
//   count_o      : number of valid entries, 0..2
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  output fetch_entry_t head_o,
  output logic [1:0]   count_o
);

  // Entry 0 is always the head; entry 1 is the slot behind it.
  fetch_entry_t e0_q, e0_d;
  fetch_entry_t e1_q, e1_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         do_pop, do_push;

  always_comb begin
    e0_d    = e0_q;
    e1_d    = e1_q;
    cnt_d   = cnt_q;
    do_pop  = pop_i && (cnt_q != 2'd0);
    do_push = push_i && ((cnt_q != 2'd2) || do_pop);

    if (flush_i) begin
      cnt_d = '0;
    end else begin
      case (cnt_q)
        2'd0: begin
          if (do_push) begin
            e0_d  = push_data_i;
            cnt_d = 2'd1;
          end
        end
        2'd1: begin
          if (do_push && do_pop) begin
            e0_d = push_data_i;
          end else if (do_push) begin
            e1_d  = push_data_i;
            cnt_d = 2'd2;
          end else if (do_pop) begin
            cnt_d = 2'd0;
          end
        end
        2'd2: begin
          // Pop shifts the second entry forward; a simultaneous push refills it.
          if (do_pop) begin
            e0_d = e1_q;
            if (do_push) begin
              e1_d = push_data_i;
            end else begin
              cnt_d = 2'd1;
            end
          end
        end
        default: cnt_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= '0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

  assign head_o  = e0_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch-stage controller: owns the PC, addresses the combinational ROM,
// buffers {pc, instr} pairs for decode and handles redirects and faults.
//   clk, rst_n      : clock, asynchronous active-low reset
//   fetch_en        : allow new fetches (buffer drains regardless)
//   imem_addr       : ROM byte address (= pc register)
//   imem_rdata      : ROM data for imem_addr, same cycle
//   redirect_valid  : load redirect_pc this cycle, flushing the buffer
//   redirect_pc     : redirect target byte address
//   out_valid/ready : decode handshake for the buffer head
//   out_pc/instr    : head entry
//   fault, fault_pc : sticky fetch fault and offending address
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        fault,
  output logic [31:0] fault_pc
);

  localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);
  localparam logic [1:0]  DEPTH_Q     = 2'(BUF_DEPTH);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  fault_pc_q, fault_pc_d;

  logic         pop, push, flush;
  fetch_entry_t push_data, head;
  logic [1:0]   count;

  assign out_valid = (count != 2'd0) && (state_q == FETCH_RUN);
  assign pop       = out_valid && out_ready;
  assign push_data = '{pc: pc_q, instr: imem_rdata};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fault_pc_d = fault_pc_q;
    push       = 1'b0;
    flush      = 1'b0;

    if (state_q == FETCH_RUN) begin
      if (redirect_valid) begin
        flush = 1'b1;
        if (word_aligned(redirect_pc[1:0])) begin
          pc_d = redirect_pc;
        end else begin
          state_d    = FETCH_FAULT;
          fault_pc_d = redirect_pc;
        end
      end else if (fetch_en) begin
        if (!pc_in_range(pc_q, MEM_WORDS_W)) begin
          state_d    = FETCH_FAULT;
          fault_pc_d = pc_q;
          flush      = 1'b1;
        end else if ((count < DEPTH_Q) || pop) begin
          push = 1'b1;
          pc_d = pc_q + 32'(INSTR_BYTES);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH_RUN;
      pc_q       <= RESET_PC;
      fault_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  fetch_skid_buf u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (count)
  );

  assign imem_addr = pc_q;
  assign out_pc    = head.pc;
  assign out_instr = head.instr;
  assign fault     = (state_q == FETCH_FAULT);
  assign fault_pc  = fault_pc_q;

endmodule
